// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one load/store per instruction over a
// req/ready handshake, formats store lanes and extends load data for writeback.
module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_inst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] exe_result,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_result,
  output logic [31:0] wb_inst,
  output logic        freeze_cpu,
  output logic        misalign_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] result_q, result_d;
  logic [31:0] wb_inst_q, wb_inst_d;
  logic        err_q, err_d;

  logic [2:0]  f3;
  logic [1:0]  off;
  logic        is_load, is_store, f3_ok, align_ok, legal, illegal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  assign f3       = mem_inst[14:12];
  assign off      = mem_addr[1:0];
  assign is_load  = (mem_inst[6:0] == 7'b0000011);
  assign is_store = (mem_inst[6:0] == 7'b0100011);

  always_comb begin
    f3_ok = 1'b0;
    case (f3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = is_load;
      default:                f3_ok = 1'b0;
    endcase
    case (f3[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~off[0];
      default: align_ok = (off == 2'b00);
    endcase
  end

  assign legal   = (is_load | is_store) & f3_ok & align_ok;
  assign illegal = (is_load | is_store) & ~legal;

  always_comb begin
    case (f3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << off;
        st_wdata = {4{exe_result[7:0]}};
      end
      2'b01: begin
        st_be    = off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{exe_result[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = exe_result;
      end
    endcase
  end

  // Lane selection uses the offset/funct3 latched at issue, not the live inputs.
  assign ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = dmem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'h0, ld_byte};
      3'b101:  ld_val = {16'h0, ld_half};
      default: ld_val = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    f3_d      = f3_q;
    off_d     = off_q;
    hold_d    = hold_q;
    result_d  = result_q;
    wb_inst_d = wb_inst_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal) begin
          addr_d  = {mem_addr[31:2], 2'b00};
          we_d    = is_store;
          wdata_d = st_wdata;
          be_d    = is_store ? st_be : 4'b1111;
          f3_d    = f3;
          off_d   = off;
          req_d   = 1'b1;
          state_d = BUSY;
        end else if (illegal) begin
          result_d  = 32'h0;
          wb_inst_d = NOP;
          err_d     = 1'b1;
        end else begin
          result_d  = exe_result;
          wb_inst_d = mem_inst;
        end
      end
      BUSY: begin
        if (dmem_ready) begin
          hold_d  = we_q ? 32'h0 : ld_val;
          req_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        result_d  = hold_q;
        wb_inst_d = mem_inst;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      f3_q      <= 3'h0;
      off_q     <= 2'h0;
      hold_q    <= 32'h0;
      result_q  <= 32'h0;
      wb_inst_q <= NOP;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      hold_q    <= hold_d;
      result_q  <= result_d;
      wb_inst_q <= wb_inst_d;
      err_q     <= err_d;
    end
  end

  assign freeze_cpu   = rst_n & (((state_q == IDLE) & legal) | (state_q == BUSY));
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign mem_result   = result_q;
  assign wb_inst      = wb_inst_q;
  assign misalign_err = err_q;

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage RV32I pipeline, sitting between Execute and Writeback. It consumes the instruction, effective address and store data/ALU result that Execute registers, and runs load/store transactions to the data memory over a request/ready handshake. It aligns store data and byte enables, and extracts and extends load data. It drives `freeze_cpu` back to the pipeline while a transaction is outstanding. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters: none.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `mem_inst`  in  32  instruction in this stage (held by upstream while `freeze_cpu`=1)
- `mem_addr`  in  32  effective address for load/store
- `exe_result`  in  32  ALU result, or rs2 data for stores
- `dmem_req`  out  1  transaction request
- `dmem_we`  out  1  1 = store, 0 = load
- `dmem_addr`  out  32  word-aligned address ({mem_addr[31:2],2'b00})
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_be`  out  4  byte enables (loads: 4'b1111)
- `dmem_ready`  in  1  memory accepts/completes the request this cycle
- `dmem_rdata`  in  32  load data, valid when `dmem_ready`=1 on a load
- `mem_result`  out  32  registered result to Writeback/forwarding
- `wb_inst`  out  32  registered instruction to Writeback
- `freeze_cpu`  out  1  pipeline stall (combinational)
- `misalign_err`  out  1  one-cycle pulse: misaligned or unsupported access dropped

## Operation
- Decode: opcode 7'b0000011 is LOAD and 7'b0100011 is STORE, with funct3 = mem_inst[14:12].
- Loads supported: LB 000, LH 001, LW 010, LBU 100, LHU 101. Stores supported: SB 000, SH 001, SW 010.
- Illegal access:
  - Halfword with addr[0]=1, word with addr[1:0]≠0, or any other funct3.
  - No request is issued, `misalign_err` pulses, and the instruction retires as a NOP: `wb_inst`=32'h00000013, `mem_result`=0.
- Store formatting:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = rs2.
- Load extraction:
  - Byte = rdata[8*addr[1:0] +: 8]; halfword = rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states IDLE, BUSY, DONE:
  - IDLE, non-memory instruction: `mem_result`<=`exe_result`, `wb_inst`<=`mem_inst` each cycle; `freeze_cpu`=0.
  - IDLE, legal load/store: `freeze_cpu`=1. At the edge, register dmem_addr/we/wdata/be, set `dmem_req`<=1, go to BUSY.
  - IDLE, illegal access: `freeze_cpu`=0, NOP retire as above, stay in IDLE.
  - BUSY: `freeze_cpu`=1. When `dmem_ready`=1, capture the extracted load data (0 for stores) into a hold register, `dmem_req`<=0, go to DONE.
  - DONE: `freeze_cpu`=0. `mem_result`<=hold register, `wb_inst`<=`mem_inst`, go to IDLE. Upstream advances at this same edge, so each instruction is issued exactly once.
- Handshake:
  - req/addr/we/wdata/be stay stable from assertion until the edge where `dmem_ready` is sampled high.
  - No new request is issued in the cycle after completion.
  - `dmem_ready` is ignored outside BUSY.

## Timing
- Reset (asynchronous, active-low) values:
  - state IDLE.
  - `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `dmem_be`=0.
  - `mem_result`=0, `wb_inst`=32'h00000013, `misalign_err`=0.
  - `freeze_cpu` is forced to 0 while `rst_n`=0.
- Non-memory pass-through latency: 1 cycle.
- Load/store with ready in the first BUSY cycle:
  - `freeze_cpu` high for 2 cycles (IDLE-detect, BUSY).
  - Result on `mem_result`/`wb_inst` 1 cycle after DONE, i.e. 3 edges after the instruction enters the stage.
- Each wait cycle of `dmem_ready`=0 adds one BUSY cycle.
- Reset asserted in BUSY or DONE abandons the transaction: `dmem_req` drops immediately and no writeback occurs.
- Back-to-back memory instructions: the second one is detected in the IDLE following DONE, with no bubble beyond the FSM sequence.

## Test plan
- LW, addr 0x100, rdata 0xDEADBEEF, ready after 0 waits:
  - Required: dmem_addr 0x100, be 1111, freeze 2 cycles, mem_result 0xDEADBEEF.
- LB and LBU, addr 0x103, rdata 0x80FF_0000:
  - Required: dmem_addr 0x100; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH, addr 0x202, rs2 0x1234ABCD, ready delayed 3 cycles:
  - Required: be 1100, wdata 0xABCDABCD, req held stable 4 cycles, freeze 5 cycles.
- LW at addr 0x101:
  - Required: no dmem_req, misalign_err pulses once, wb_inst 0x00000013, mem_result 0.
- ADDI (exe_result 0x55) followed immediately by SB to 0x7 with rs2 0xA5:
  - Required: mem_result 0x55 after 1 cycle; then be 1000, wdata 0xA5A5A5A5.
- rst_n pulled low during BUSY:
  - Required: req drops asynchronously; after release, all outputs at reset values and state IDLE.
